otn_frame_tx: RTL and testbench
===============================

Name: otn_frame_tx

Overview:
Transmit-side serializer that sits directly upstream of the receiver's serial input. It accepts one mapped OTN frame as parallel bytes from the mapper and buffers it in an internal RAM. It prepends the 48-bit frame-start pattern and shifts the frame out MSB-first on a 1-bit line. When ARQ is enabled, it waits for the 3-bit serial ACK from the receiver and retransmits on a bad ACK or timeout, up to a retry limit.

Parameters:
FRAME_BYTES, 4158, payload bytes per frame (mapper output including CRC)
FRAME_START, 48'hF6F6F6282828, start pattern, sent MSB first
GAP_BITS, 16, idle-high bit times inserted after every frame or ACK exchange
ACK_TIMEOUT, 64, cycles to wait for the ACK start bit after the last payload bit
MAX_RETRY, 3, retransmissions allowed before the frame is dropped

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_frame_data  in  8  payload byte from the mapper
i_frame_data_valid  in  1  byte valid
o_frame_data_ready  out  1  block accepts a byte this cycle (valid&&ready = transfer)
i_arq_en  in  1  ARQ enable value
i_arq_en_valid  in  1  qualifies i_arq_en
o_otn_tx_data  out  1  serial line to the receiver, idle high
i_otn_rx_ack  in  1  serial ACK from the receiver, idle high
o_frame_sent  out  1  1-cycle pulse: frame completed (good ACK, or end of payload when ARQ is off)
o_frame_drop  out  1  1-cycle pulse: retries exhausted, frame discarded
o_busy  out  1  high in every state except IDLE

Behaviour:
- All state bits update on the rising edge of i_clk. i_rst forces the following values on the next edge, including mid-frame, with no flush:
  - state=IDLE; o_otn_tx_data=1; o_frame_data_ready=0; pulses=0; counters=0; r_arq_en=0.
- r_arq_en captures i_arq_en when i_arq_en_valid=1, in any state. Its value is frozen into f_arq when LOAD is entered, so a change mid-frame affects only the next frame.
- i_otn_rx_ack passes through a 2-flop synchronizer (ack_s). Only ack_s is used.
- Buffer: FRAME_BYTES x 8 RAM, write address wr_cnt and read address rd_cnt. Registered read with 1-cycle latency; the shift register is preloaded one byte ahead.
- States:
  - IDLE: line=1, ready=0. Moves to LOAD after a clean idle of at least GAP_BITS cycles (gap counter) when leaving SEND_PAYLOAD, WAIT_ACK or a drop.
  - LOAD: ready=1.
    - Each valid&&ready writes RAM[wr_cnt] and increments wr_cnt.
    - When wr_cnt reaches FRAME_BYTES-1 with a transfer: ready drops the next cycle, retry_cnt=0, go to SEND_HDR.
  - SEND_HDR: 48 cycles, one pattern bit per cycle, FRAME_START[47] first. Then SEND_PAYLOAD.
  - SEND_PAYLOAD: FRAME_BYTES*8 cycles, each byte bit 7 first, no gaps between bytes or between header and payload. After the last bit:
    - if f_arq=0: pulse o_frame_sent, go to IDLE (gap).
    - if f_arq=1: go to WAIT_ACK.
  - WAIT_ACK: line=1; timer counts up from 0.
    - ack_s=0: the next cycle samples the data bit, and the cycle after that samples the stop bit.
    - Good ACK = data 1 and stop 0: pulse o_frame_sent, go to IDLE.
    - Bad ACK = data 0, or stop bit not 0: treated as a failed attempt.
    - Timeout = timer reaches ACK_TIMEOUT with no start bit: treated as a failed attempt.
  - Failed attempt:
    - if retry_cnt<MAX_RETRY: retry_cnt+1, wait GAP_BITS idle cycles, rd_cnt=0, go to SEND_HDR.
    - otherwise: pulse o_frame_drop, go to IDLE.
- o_otn_tx_data is registered, so the first header bit appears the cycle after SEND_HDR is entered. The line is 1 in every non-transmitting cycle.
- Counter widths: wr_cnt/rd_cnt = clog2(FRAME_BYTES); bit_cnt is 3 bits; hdr_cnt is 6 bits; timer = clog2(ACK_TIMEOUT+1).
- Counters do not wrap. Each one is cleared on its state entry.
- The input never overflows: ready is 0 outside LOAD. Upstream holds data while ready=0.
- ACK glitches outside WAIT_ACK are ignored.

Test Plan:
- ARQ off, frame bytes 0x00..0xFF repeating (4158 bytes) -> line shows F6F6F6282828 then payload MSB-first; o_frame_sent pulses 1 cycle after the last bit; a second frame's header starts no earlier than 16 idle-high cycles later.
- ARQ on, receiver model returns bits 0,1,0 10 cycles after the payload -> o_frame_sent=1, no retransmit, o_busy falls.
- ARQ on, ACK 0,0,0 twice, then 0,1,0 -> exactly 3 identical transmissions; one o_frame_sent; no drop.
- ARQ on, ACK line held 1 -> 4 transmissions (1 + MAX_RETRY), each ending 64 cycles after the last bit; then o_frame_drop pulses and the block returns to IDLE.
- Backpressure: i_frame_data_valid toggles every other cycle in LOAD -> all 4158 bytes are captured in order; ready=0 during transmit, and offered bytes are not consumed.
- i_rst asserted mid-payload, and i_arq_en_valid mid-frame -> the next edge gives line=1, IDLE, and all counters 0. The arq change applies only to the frame loaded after it.

Source files
------------

// File: rtl/otn_frame_tx.sv
// otn_frame_tx: buffers one mapped OTN frame, then serializes FRAME_START + payload MSB-first on a
//   1-bit idle-high line; with ARQ on it waits for a 3-bit serial ACK and retransmits up to MAX_RETRY times.
// Latency: first header bit appears on o_otn_tx_data one cycle after the last payload byte is accepted.
// Backpressure: o_frame_data_ready is high only in LOAD; upstream holds its byte while ready is low.
// Ports: i_frame_data/_valid/o_frame_data_ready = byte input; i_arq_en/_valid = ARQ mode;
//   o_otn_tx_data = serial line; i_otn_rx_ack = serial ACK; o_frame_sent/o_frame_drop = 1-cycle
//   completion pulses; o_busy = not IDLE.
module otn_frame_tx #(
    parameter int          FRAME_BYTES = 4158,
    parameter logic [47:0] FRAME_START = 48'hF6F6F6282828,
    parameter int          GAP_BITS    = 16,
    parameter int          ACK_TIMEOUT = 64,
    parameter int          MAX_RETRY   = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_frame_data,
    input  logic       i_frame_data_valid,
    output logic       o_frame_data_ready,
    input  logic       i_arq_en,
    input  logic       i_arq_en_valid,
    output logic       o_otn_tx_data,
    input  logic       i_otn_rx_ack,
    output logic       o_frame_sent,
    output logic       o_frame_drop,
    output logic       o_busy
);
    localparam int AW = $clog2(FRAME_BYTES);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_BITS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SEND_HDR, SEND_PAYLOAD, WAIT_ACK, RETRY_GAP
    } state_t;

    typedef enum logic [1:0] {
        ACK_START, ACK_DATA, ACK_STOP
    } ack_ph_t;

    state_t          state, state_nxt;
    ack_ph_t         ack_ph;
    logic [AW-1:0]   wr_cnt, rd_cnt;
    logic [2:0]      bit_cnt;
    logic [5:0]      hdr_cnt;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [47:0]     hdr_sr;
    logic [7:0]      shift, rd_dat;
    logic            last_byte, f_arq, r_arq_en, ack_data;
    logic            ack_meta, ack_s;
    logic            tx_data, ready, frame_sent, frame_drop, sent_pend;
    logic            sent_nxt, drop_nxt, pend_nxt, ack_fail, wr_en;

    logic [7:0] mem [FRAME_BYTES];

    assign wr_en              = i_frame_data_valid && ready;
    assign o_frame_data_ready = ready;
    assign o_otn_tx_data      = tx_data;
    assign o_frame_sent       = frame_sent;
    assign o_frame_drop       = frame_drop;
    assign o_busy             = (state != IDLE);

    // Frame buffer: registered read, address held during transmit so rd_dat is always one byte ahead.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_cnt] <= i_frame_data;
        rd_dat <= mem[rd_cnt];
    end

    always_comb begin
        state_nxt = state;
        sent_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        pend_nxt  = 1'b0;
        ack_fail  = 1'b0;
        case (state)
            IDLE:      if (gap_cnt == GW'(GAP_BITS - 1)) state_nxt = LOAD;
            LOAD:      if (wr_en && wr_cnt == AW'(FRAME_BYTES - 1)) state_nxt = SEND_HDR;
            SEND_HDR:  if (hdr_cnt == 6'd47) state_nxt = SEND_PAYLOAD;
            SEND_PAYLOAD: begin
                if (bit_cnt == 3'd7 && last_byte) begin
                    if (f_arq) begin
                        state_nxt = WAIT_ACK;
                    end else begin
                        // Pulse lands the cycle after the last bit is visible on the line.
                        state_nxt = IDLE;
                        pend_nxt  = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                case (ack_ph)
                    ACK_START: if (ack_s && timer == TW'(ACK_TIMEOUT - 1)) ack_fail = 1'b1;
                    ACK_STOP: begin
                        if (ack_data && !ack_s) begin
                            sent_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ack_fail = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RETRY_GAP: if (gap_cnt == GW'(GAP_BITS - 1)) state_nxt = SEND_HDR;
            default:   state_nxt = IDLE;
        endcase
        if (ack_fail) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
                state_nxt = RETRY_GAP;
            end else begin
                state_nxt = IDLE;
                drop_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            tx_data    <= 1'b1;
            ready      <= 1'b0;
            frame_sent <= 1'b0;
            frame_drop <= 1'b0;
            sent_pend  <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            bit_cnt    <= '0;
            hdr_cnt    <= '0;
            timer      <= '0;
            gap_cnt    <= '0;
            retry_cnt  <= '0;
            ack_ph     <= ACK_START;
            ack_data   <= 1'b0;
            hdr_sr     <= '0;
            shift      <= '0;
            last_byte  <= 1'b0;
            f_arq      <= 1'b0;
            r_arq_en   <= 1'b0;
            ack_meta   <= 1'b1;
            ack_s      <= 1'b1;
        end else begin
            state      <= state_nxt;
            ready      <= (state_nxt == LOAD);
            frame_sent <= sent_nxt | sent_pend;
            sent_pend  <= pend_nxt;
            frame_drop <= drop_nxt;
            ack_meta   <= i_otn_rx_ack;
            ack_s      <= ack_meta;
            tx_data    <= 1'b1;
            if (i_arq_en_valid) r_arq_en <= i_arq_en;

            // IDLE and RETRY_GAP both count idle-high cycles from their entry.
            if (state_nxt != state) gap_cnt <= '0;
            else if (state == IDLE || state == RETRY_GAP) gap_cnt <= gap_cnt + GW'(1);

            case (state)
                LOAD: if (wr_en && wr_cnt != AW'(FRAME_BYTES - 1)) wr_cnt <= wr_cnt + AW'(1);
                SEND_HDR: begin
                    tx_data <= hdr_sr[47];
                    hdr_sr  <= {hdr_sr[46:0], 1'b0};
                    if (hdr_cnt == 6'd47) begin
                        // Preload byte 0 so payload follows the header with no gap.
                        shift     <= rd_dat;
                        bit_cnt   <= '0;
                        last_byte <= (rd_cnt == AW'(FRAME_BYTES - 1));
                        if (rd_cnt != AW'(FRAME_BYTES - 1)) rd_cnt <= rd_cnt + AW'(1);
                    end else begin
                        hdr_cnt <= hdr_cnt + 6'd1;
                    end
                end
                SEND_PAYLOAD: begin
                    tx_data <= shift[7];
                    if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (!last_byte) begin
                            shift     <= rd_dat;
                            last_byte <= (rd_cnt == AW'(FRAME_BYTES - 1));
                            if (rd_cnt != AW'(FRAME_BYTES - 1)) rd_cnt <= rd_cnt + AW'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[6:0], 1'b0};
                    end
                end
                WAIT_ACK: begin
                    case (ack_ph)
                        ACK_START: begin
                            if (!ack_s) ack_ph <= ACK_DATA;
                            else        timer  <= timer + TW'(1);
                        end
                        ACK_DATA: begin
                            ack_data <= ack_s;
                            ack_ph   <= ACK_STOP;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            // Entry actions take precedence over the per-state updates above.
            if (state_nxt != state) begin
                case (state_nxt)
                    LOAD: begin
                        wr_cnt <= '0;
                        f_arq  <= r_arq_en;
                    end
                    SEND_HDR: begin
                        hdr_cnt   <= '0;
                        rd_cnt    <= '0;
                        hdr_sr    <= FRAME_START;
                        last_byte <= 1'b0;
                        if (state == LOAD) retry_cnt <= '0;
                    end
                    WAIT_ACK: begin
                        timer  <= '0;
                        ack_ph <= ACK_START;
                    end
                    RETRY_GAP: retry_cnt <= retry_cnt + RW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_otn_frame_tx.sv
// Bench for otn_frame_tx with a short frame so every ARQ scenario fits a small cycle budget.
// A line monitor hunts for the start pattern, rebuilds payload bytes and compares them with the loaded frame.
// Receiver ACKs are driven as start/data/stop bit sequences a few cycles after each transmission.
module tb_otn_frame_tx;
    localparam int          FB  = 64;
    localparam logic [47:0] FS  = 48'hF6F6F6282828;
    localparam int          GAP = 16;
    localparam int          TO  = 64;
    localparam int          MR  = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] fdata   = '0;
    logic       fvalid  = 1'b0;
    logic       fready;
    logic       arq     = 1'b0;
    logic       arq_vld = 1'b0;
    logic       tx_line;
    logic       ack     = 1'b1;
    logic       sent, drop, busy;

    otn_frame_tx #(
        .FRAME_BYTES (FB),
        .FRAME_START (FS),
        .GAP_BITS    (GAP),
        .ACK_TIMEOUT (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_frame_data       (fdata),
        .i_frame_data_valid (fvalid),
        .o_frame_data_ready (fready),
        .i_arq_en           (arq),
        .i_arq_en_valid     (arq_vld),
        .o_otn_tx_data      (tx_line),
        .i_otn_rx_ack       (ack),
        .o_frame_sent       (sent),
        .o_frame_drop       (drop),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the frame most recently handed to the DUT.
    logic [7:0] cur_frame [FB];

    // Line monitor state
    logic [47:0] win = '1;
    bit          cap = 1'b0;
    int          nbits = 0;
    logic [7:0]  rx [FB];
    int          mon_bad;
    int          tx_count = 0;
    int          last_end = -1000;
    int          sent_cnt = 0, drop_cnt = 0;
    int          sent_cyc = 0, drop_cyc = 0;
    logic        sent_busy = 1'b1, drop_busy = 1'b1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cap = 1'b0;
            win = '1;
        end else begin
            win = {win[46:0], tx_line};
            if (!cap) begin
                if (win == FS) begin
                    check("hdr_gap_ge_16", ((cyc - 47 - last_end - 1) >= GAP), 1'b1);
                    cap   = 1'b1;
                    nbits = 0;
                end
            end else begin
                rx[nbits / 8] = {rx[nbits / 8][6:0], tx_line};
                nbits++;
                if (nbits == FB * 8) begin
                    mon_bad = 0;
                    for (int i = 0; i < FB; i++)
                        if (rx[i] !== cur_frame[i]) mon_bad++;
                    check("payload_bytes_bad", mon_bad, 0);
                    cap      = 1'b0;
                    win      = '1;
                    tx_count++;
                    last_end = cyc;
                end
            end
        end
        if (sent === 1'b1) begin
            sent_cnt++;
            sent_cyc  = cyc;
            sent_busy = busy;
        end
        if (drop === 1'b1) begin
            drop_cnt++;
            drop_cyc  = cyc;
            drop_busy = busy;
        end
    end

    task automatic fill_frame(input bit ramp);
        for (int i = 0; i < FB; i++)
            cur_frame[i] = ramp ? 8'(i % 256) : 8'($urandom_range(0, 255));
    endtask

    task automatic load_frame(input bit bp);
        int  idx = 0;
        int  g   = 0;
        bit  tog = 1'b1;
        bit  xfer;
        while (idx < FB && g < 20 * FB + 1000) begin
            @(negedge clk);
            fdata  = cur_frame[idx];
            fvalid = bp ? tog : 1'b1;
            tog    = !tog;
            xfer   = fvalid && fready;
            @(posedge clk);
            if (xfer) idx++;
            g++;
        end
        @(negedge clk);
        fvalid = 1'b0;
        check("load_bytes", idx, FB);
    endtask

    // Waits for n completed transmissions; optionally offers a byte meanwhile and counts ready.
    task automatic wait_tx(input int n, input bit offer, output int ready_hi);
        int g = 0;
        ready_hi = 0;
        if (offer) begin
            fdata  = 8'h5A;
            fvalid = 1'b1;
        end
        while (tx_count < n && g < 10000) begin
            @(negedge clk);
            if (fready === 1'b1) ready_hi++;
            g++;
        end
        fvalid = 1'b0;
        check("tx_reached", tx_count >= n, 1'b1);
    endtask

    task automatic wait_bits(input int n);
        int g = 0;
        while (!(cap && nbits >= n) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("bits_reached", (cap && nbits >= n), 1'b1);
    endtask

    task automatic wait_sent(input int n);
        int g = 0;
        while (sent_cnt < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("sent_reached", sent_cnt >= n, 1'b1);
    endtask

    task automatic wait_drop(input int n);
        int g = 0;
        while (drop_cnt < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drop_reached", drop_cnt >= n, 1'b1);
    endtask

    task automatic send_ack(input logic d, input logic s);
        repeat (10) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        ack = d;
        @(negedge clk);
        ack = s;
        @(negedge clk);
        ack = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_hi;
        int base;

        repeat (3) @(negedge clk);
        check("rst_line", tx_line, 1'b1);
        check("rst_ready", fready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", sent, 1'b0);
        check("rst_drop", drop, 1'b0);
        rst = 1'b0;

        // A: ARQ off, ramp payload; ARQ is enabled mid-payload and must not affect this frame.
        fill_frame(1'b1);
        load_frame(1'b0);
        wait_bits(200);
        arq     = 1'b1;
        arq_vld = 1'b1;
        @(negedge clk);
        arq_vld = 1'b0;
        wait_tx(1, 1'b0, rdy_hi);
        repeat (4) @(negedge clk);
        check("A_sent_cnt", sent_cnt, 1);
        check("A_sent_delay", sent_cyc - last_end, 1);
        check("A_sent_busy", sent_busy, 1'b0);
        check("A_drop_cnt", drop_cnt, 0);

        // B: ARQ on (from the mid-frame change), backpressured load, good ACK 0,1,0.
        fill_frame(1'b0);
        load_frame(1'b1);
        wait_tx(2, 1'b1, rdy_hi);
        check("B_ready_in_tx", rdy_hi, 0);
        send_ack(1'b1, 1'b0);
        wait_sent(2);
        check("B_sent_after_ack", (sent_cyc - last_end) > 10, 1'b1);
        check("B_sent_busy", sent_busy, 1'b0);
        repeat (100) @(negedge clk);
        check("B_tx_count", tx_count, 2);
        check("B_sent_cnt", sent_cnt, 2);

        // C: bad data, bad stop, then good ACK -> three identical transmissions.
        base = tx_count;
        fill_frame(1'b0);
        load_frame(1'b0);
        for (int a = 0; a < 3; a++) begin
            wait_tx(base + a + 1, 1'b0, rdy_hi);
            if (a == 0)      send_ack(1'b0, 1'b0);
            else if (a == 1) send_ack(1'b1, 1'b1);
            else             send_ack(1'b1, 1'b0);
        end
        wait_sent(3);
        repeat (100) @(negedge clk);
        check("C_tx_count", tx_count - base, 3);
        check("C_sent_cnt", sent_cnt, 3);
        check("C_drop_cnt", drop_cnt, 0);

        // D: ACK line held high -> 1 + MAX_RETRY transmissions, then drop after the timeout.
        base = tx_count;
        fill_frame(1'b0);
        load_frame(1'b0);
        wait_tx(base + MR + 1, 1'b0, rdy_hi);
        wait_drop(1);
        check("D_drop_delay", drop_cyc - last_end, TO);
        check("D_drop_busy", drop_busy, 1'b0);
        repeat (100) @(negedge clk);
        check("D_tx_count", tx_count - base, MR + 1);
        check("D_drop_cnt", drop_cnt, 1);
        check("D_sent_cnt", sent_cnt, 3);

        // E: reset mid-payload, then a fresh frame must go out with ARQ off.
        fill_frame(1'b0);
        load_frame(1'b0);
        wait_bits(100);
        rst = 1'b1;
        @(negedge clk);
        check("E_rst_line", tx_line, 1'b1);
        check("E_rst_busy", busy, 1'b0);
        check("E_rst_ready", fready, 1'b0);
        check("E_rst_sent", sent, 1'b0);
        check("E_rst_drop", drop, 1'b0);
        rst = 1'b0;
        base = tx_count;
        fill_frame(1'b0);
        load_frame(1'b0);
        wait_tx(base + 1, 1'b0, rdy_hi);
        repeat (4) @(negedge clk);
        check("E_tx_count", tx_count - base, 1);
        check("E_sent_cnt", sent_cnt, 4);
        check("E_sent_delay", sent_cyc - last_end, 1);
        check("E_drop_cnt", drop_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
